// File: rtl/mc_sequencer_pkg.sv
// mc_sequencer_pkg
//   Shared instruction definitions for the micro-controller sequencer slice:
//   opcode enumeration, opcode field position (relative to the operand
//   field, so it follows the program-counter width), sequencer run/halt
//   states and a small sizing helper for the return-stack pointer.
package mc_sequencer_pkg;

  localparam int OPC_W   = 4;
  // Opcode bit positions counted from the first bit above the operand field.
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = OPC_W - 1;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_JMP  = 4'h1,
    OPC_CALL = 4'h2,
    OPC_RTN  = 4'h3,
    OPC_OUT  = 4'h4,
    OPC_IN   = 4'h5,
    OPC_HALT = 4'h6
  } opcode_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

  // Pointer width able to hold 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mc_return_stack.sv
// mc_return_stack
//   LIFO of return addresses for subroutine calls.
//   Ports:
//     clk, rst          clock, synchronous active-low reset (empties stack)
//     push, data_in     store data_in on top (ignored when full)
//     pop               discard top entry (ignored when empty)
//     top               most recently pushed entry (undefined when empty)
//     full, empty       occupancy flags
module mc_return_stack
  import mc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = sp_width(STACK_D);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [ADDR_W-1:0] r_mem [STACK_D];
  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_m1;

  assign w_sp_m1 = r_sp - SP_W'(1);
  assign full    = (r_sp == SP_W'(STACK_D));
  assign empty   = (r_sp == {SP_W{1'b0}});
  assign top     = r_mem[w_sp_m1[IDX_W-1:0]];

  // Stack pointer: push has precedence; the sequencer never asserts both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp <= {SP_W{1'b0}};
    end else if (push && !full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (pop && !empty) begin
      r_sp <= w_sp_m1;
    end else begin
      r_sp <= r_sp;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (rst && push && !full) begin
      r_mem[r_sp[IDX_W-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Program counter sequencer with call/return stack and halt control.
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     rom_addr                 program memory address (= pc)
//     rom_data                 {opcode, operand} word at rom_addr
//     instruction, io_addr     opcode / operand fields of rom_data
//     jmp, rtn, flag_o, flag_f decoded-instruction strobes for current word
//     run                      resume pulse while halted
//     halted                   sequencer stopped
//     stack_err                sticky stack overflow/underflow
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [ADDR_W+3:0]     rom_data,
  output logic [3:0]            instruction,
  output logic [ADDR_W-1:0]     io_addr,
  input  logic                  jmp,
  input  logic                  rtn,
  input  logic                  flag_o,
  input  logic                  flag_f,
  input  logic                  run,
  output logic                  halted,
  output logic                  stack_err
);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_operand;
  logic [ADDR_W-1:0] w_top;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_err_set;
  logic              r_stack_err;
  opcode_t           w_opcode;

  assign w_operand   = rom_data[ADDR_W-1:0];
  assign w_opcode    = opcode_t'(rom_data[ADDR_W+OPC_MSB:ADDR_W+OPC_LSB]);
  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign rom_addr    = r_pc;
  assign instruction = w_opcode;
  assign io_addr     = w_operand;
  assign halted      = (r_state == ST_HALT);
  assign stack_err   = r_stack_err;

  mc_return_stack #(
    .ADDR_W  (ADDR_W),
    .STACK_D (STACK_D)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .data_in (w_pc_inc),
    .top     (w_top),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Next-pc priority: rtn > flag_f > jmp > flag_o > increment; halt holds.
  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (rtn) begin
          if (w_empty) begin
            // Underflow: behave like a plain increment.
            w_pc_next = w_pc_inc;
            w_err_set = 1'b1;
          end else begin
            w_pop     = 1'b1;
            w_pc_next = w_top;
          end
        end else if (flag_f) begin
          // Overflow drops the return address but still takes the call.
          w_pc_next = w_operand;
          if (w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end else if (jmp) begin
          w_pc_next = w_operand;
        end else if (flag_o) begin
          w_pc_next    = w_pc_inc;
          w_state_next = ST_HALT;
        end else begin
          w_pc_next = w_pc_inc;
        end
      end
      ST_HALT: begin
        // Only run is honoured; pc resumes on the edge after this one.
        if (run) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_HALT;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State, pc and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_pc        <= {ADDR_W{1'b0}};
      r_stack_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_stack_err <= r_stack_err | w_err_set;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

  localparam int AW = 8;
  localparam int SD = 4;
  localparam int NPC = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [AW+3:0] rom_data;
  logic [3:0]    instruction;
  logic [AW-1:0] io_addr;
  logic          jmp, rtn, flag_o, flag_f, run;
  logic          halted, stack_err;

  logic [AW+3:0] rom [NPC];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_halt;
  bit m_err;

  assign rom_data = rom[rom_addr];

  mc_sequencer #(.ADDR_W(AW), .STACK_D(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instruction (instruction),
    .io_addr     (io_addr),
    .jmp         (jmp),
    .rtn         (rtn),
    .flag_o      (flag_o),
    .flag_f      (flag_f),
    .run         (run),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW+3:0] w;
    w = rom[m_pc];
    chk({tag, ".rom_addr"},    32'(rom_addr),    32'(m_pc));
    chk({tag, ".instruction"}, 32'(instruction), 32'(w[AW+3:AW]));
    chk({tag, ".io_addr"},     32'(io_addr),     32'(w[AW-1:0]));
    chk({tag, ".halted"},      32'(halted),      32'(m_halt));
    chk({tag, ".stack_err"},   32'(stack_err),   32'(m_err));
  endtask

  // Behavioural model of one edge, straight from the sequencing rules.
  task automatic model_edge(input bit j, input bit r, input bit fo, input bit ff,
                            input bit rn, input bit rs);
    logic [AW+3:0] w;
    int op;
    w  = rom[m_pc];
    op = int'(w[AW-1:0]);
    if (!rs) begin
      m_pc = 0; m_stk.delete(); m_halt = 0; m_err = 0;
    end else if (m_halt) begin
      if (rn) m_halt = 0;
    end else if (r) begin
      if (m_stk.size() == 0) begin
        m_pc = (m_pc + 1) % NPC; m_err = 1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (ff) begin
      if (m_stk.size() == SD) m_err = 1;
      else m_stk.push_back((m_pc + 1) % NPC);
      m_pc = op;
    end else if (j) begin
      m_pc = op;
    end else if (fo) begin
      m_pc = (m_pc + 1) % NPC; m_halt = 1;
    end else begin
      m_pc = (m_pc + 1) % NPC;
    end
  endtask

  task automatic step(input string tag, input bit j, input bit r, input bit fo,
                      input bit ff, input bit rn, input bit rs);
    jmp = j; rtn = r; flag_o = fo; flag_f = ff; run = rn; rst = rs;
    model_edge(j, r, fo, ff, rn, rs);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_operand(input int target);
    logic [AW+3:0] w;
    w = rom[m_pc];
    w[AW-1:0] = AW'(target);
    rom[m_pc] = w;
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) rom[i] = (AW+4)'($urandom);
    jmp = 1'b0; rtn = 1'b0; flag_o = 1'b0; flag_f = 1'b0; run = 1'b0; rst = 1'b0;
    m_pc = 0; m_halt = 0; m_err = 0;

    // Reset, then idle count 0..5
    step("reset", 0, 0, 0, 0, 0, 0);
    step("reset2", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0, 1);

    // Halt at 0x05, ignore jmp for 10 edges, then run
    step("flag_o", 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("halt_hold", i[0], i[1], i[2], 0, 0, 1);
    step("run", 0, 0, 1, 0, 1, 1);
    step("resume", 0, 0, 0, 0, 0, 1);
    step("run_ignored", 0, 0, 0, 0, 1, 1);

    // Jumps: reach 0x10, jump to 0x40
    set_operand(8'h10); step("jmp_to10", 1, 0, 0, 0, 0, 1);
    set_operand(8'h40); step("jmp_to40", 1, 0, 0, 0, 0, 1);

    // Call from 0x20 to 0x80, then return to 0x21
    set_operand(8'h20); step("jmp_to20", 1, 0, 0, 0, 0, 1);
    set_operand(8'h80); step("call80", 0, 0, 0, 1, 0, 1);
    step("idle_in_sub", 0, 0, 0, 0, 0, 1);
    step("rtn", 0, 1, 0, 0, 0, 1);

    // Priority on a shared edge: rtn over call, call over jmp
    step("prio_call", 1, 0, 1, 1, 0, 1);
    step("prio_rtn", 1, 1, 1, 1, 0, 1);

    // Five nested calls, 4 returns, one underflow
    for (int i = 0; i < 5; i++) step("nest_call", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step("nest_rtn", 0, 1, 0, 0, 0, 1);

    // Wrap 0xFF -> 0x00
    set_operand(8'hFF); step("jmp_toFF", 1, 0, 0, 0, 0, 1);
    step("wrap", 0, 0, 0, 0, 0, 1);

    // Reset while halted with two return addresses stacked
    step("call_a", 0, 0, 0, 1, 0, 1);
    step("call_b", 0, 0, 0, 1, 0, 1);
    step("halt2", 0, 0, 1, 0, 0, 1);
    step("rst_in_halt", 1, 1, 0, 1, 1, 0);
    step("post_rst_rtn", 0, 1, 0, 0, 0, 1);
    step("call_c", 0, 0, 0, 1, 0, 1);
    step("rst_with_call", 0, 0, 0, 1, 0, 0);

    // Randomised strobes against the model
    for (int i = 0; i < 600; i++) begin
      bit j, r, fo, ff, rn, rs;
      j  = ($urandom_range(0, 99) < 15);
      r  = ($urandom_range(0, 99) < 15);
      fo = ($urandom_range(0, 99) < 8);
      ff = ($urandom_range(0, 99) < 18);
      rn = ($urandom_range(0, 99) < 25);
      rs = ($urandom_range(0, 99) >= 2);
      step("random", j, r, fo, ff, rn, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
